// File: rtl/mem_bus_master.sv
// Initiator for the shared-tristate data-memory bus: one aligned load/store per request,
// byte-lane generation, a single CS cycle (plus wait states) and an extended load response.
module mem_bus_master #(
    parameter int WORD_ADDR   = 1,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        CS,
    output logic [3:0]  WE,
    output logic [31:0] ADDR,
    inout  wire logic [31:0] Mem_Bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_r, state_s;
    logic        cs_r, cs_s;
    logic [3:0]  we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] bus_data_r, bus_data_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [1:0]  boff_r, boff_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        store_r, store_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_err_r, rsp_err_s;

    function automatic logic req_illegal(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = st;
            3'b101:  bad = st | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b1111;
        case (size)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] a);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {a, 3'b000};
        r = s;
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'h000000, s[7:0]};
            3'b101:  r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Next-state and next-output decode for the IDLE/ACCESS/RESP sequence
    always_comb begin
        state_s     = state_r;
        cs_s        = cs_r;
        we_s        = we_r;
        addr_s      = addr_r;
        bus_data_s  = bus_data_r;
        funct3_s    = funct3_r;
        boff_s      = boff_r;
        cnt_s       = cnt_r;
        store_s     = store_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_illegal(req_store, req_funct3, req_addr[1:0])) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = 32'h0000_0000;
                    end else begin
                        state_s    = ST_ACCESS;
                        cs_s       = 1'b1;
                        we_s       = req_store ? lane_mask(req_funct3[1:0], req_addr[1:0]) : 4'b0000;
                        addr_s     = (WORD_ADDR != 0) ? {2'b00, req_addr[31:2]} : req_addr;
                        bus_data_s = lane_data(req_funct3[1:0], req_wdata);
                        funct3_s   = req_funct3;
                        boff_s     = req_addr[1:0];
                        cnt_s      = WAIT_INIT;
                        store_s    = req_store;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Final edge of the bus cycle: sample read data and release the bus
                if (cnt_r == 4'd0) begin
                    state_s     = ST_RESP;
                    cs_s        = 1'b0;
                    we_s        = 4'b0000;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = store_r ? 32'h0000_0000 : load_extend(funct3_r, Mem_Bus, boff_r);
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cs_s        = 1'b0;
                we_s        = 4'b0000;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any bus cycle in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            cs_r        <= 1'b0;
            we_r        <= 4'b0000;
            addr_r      <= 32'h0000_0000;
            bus_data_r  <= 32'h0000_0000;
            funct3_r    <= 3'b000;
            boff_r      <= 2'b00;
            cnt_r       <= 4'd0;
            store_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cs_r        <= cs_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            bus_data_r  <= bus_data_s;
            funct3_r    <= funct3_s;
            boff_r      <= boff_s;
            cnt_r       <= cnt_s;
            store_r     <= store_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign CS        = cs_r;
    assign WE        = we_r;
    assign ADDR      = addr_r;
    // Only writes put data on the shared bus; reads leave it to the memory
    assign Mem_Bus   = ((state_r == ST_ACCESS) && (we_r != 4'b0000)) ? bus_data_r : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a word memory on each bus, a byte-level reference model
// checked every cycle, and directed transactions with literal expected results.
module tb_mem_bus_master;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid0 = 1'b0, req_valid1 = 1'b0, req_store = 1'b0;
    logic        rsp_ready0 = 1'b1, rsp_ready1 = 1'b1;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

    logic        req_ready0, rsp_valid0, rsp_err0, cs0;
    logic [31:0] rsp_rdata0, addr0;
    logic [3:0]  we0;
    wire  [31:0] bus0;
    logic        req_ready1, rsp_valid1, rsp_err1, cs1;
    logic [31:0] rsp_rdata1, addr1;
    logic [3:0]  we1;
    wire  [31:0] bus1;

    logic [31:0] mem [0:63];
    logic [7:0]  mb  [0:255];
    int total = 0, bad = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    mem_bus_master #(.WORD_ADDR(1), .WAIT_CYCLES(0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .CS(cs0), .WE(we0), .ADDR(addr0), .Mem_Bus(bus0));

    mem_bus_master #(.WORD_ADDR(1), .WAIT_CYCLES(2)) u2 (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .CS(cs1), .WE(we1), .ADDR(addr1), .Mem_Bus(bus1));

    assign bus0 = (cs0 && we0 == 4'b0000) ? mem[addr0[5:0]] : 32'hzzzz_zzzz;
    assign bus1 = (cs1 && we1 == 4'b0000) ? mem[addr1[5:0]] : 32'hzzzz_zzzz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory device: latches enabled byte lanes on the negedge inside a write cycle
    always @(negedge CLK) begin
        if (cs0) begin
            for (int i = 0; i < 4; i++)
                if (we0[i]) mem[addr0[5:0]][8*i +: 8] = bus0[8*i +: 8];
        end
    end

    // Reference model: one outstanding request, byte-addressed memory image
    int          m_cs_left = 0, m_size = 1;
    bit          m_rsp_v = 1'b0, m_err = 1'b0, m_store = 1'b0;
    logic [31:0] m_rdata = 32'h0, m_addr = 32'h0, m_bus = 32'h0, m_wd = 32'h0, m_a = 32'h0;
    logic [3:0]  m_we = 4'b0;

    task automatic model_accept();
        int sz;
        logic [31:0] a, v, msk;
        logic [2:0] f3;
        bit ill;
        f3 = req_funct3;
        a  = req_addr;
        sz = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        ill = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (req_store && f3[2]) || ((a % sz) != 0);
        m_store = req_store; m_a = a; m_size = sz; m_wd = req_wdata;
        if (ill) begin
            m_rsp_v = 1'b1; m_err = 1'b1; m_rdata = 32'h0;
        end else begin
            m_err = 1'b0;
            m_cs_left = 1;
            m_addr = {2'b00, a[31:2]};
            for (int i = 0; i < 4; i++) begin
                m_we[i] = req_store && (i >= int'(a[1:0])) && (i < int'(a[1:0]) + sz);
                m_bus[8*i +: 8] = req_wdata[8*(i % sz) +: 8];
            end
            if (req_store) m_rdata = 32'h0;
            else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v = v | ({24'h0, mb[(a + i) & 255]} << (8*i));
                msk = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
                if (!f3[2] && v[8*sz-1]) v = v | ~msk;
                m_rdata = v;
            end
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_cs_left = 0; m_rsp_v = 1'b0;
        end else if (m_cs_left == 0 && !m_rsp_v) begin
            if (req_valid0) model_accept();
        end else if (m_cs_left > 0) begin
            m_cs_left--;
            if (m_cs_left == 0) begin
                if (m_store) for (int i = 0; i < m_size; i++) mb[(m_a + i) & 255] = m_wd[8*i +: 8];
                m_rsp_v = 1'b1;
            end
        end else if (rsp_ready0) begin
            m_rsp_v = 1'b0;
        end
    end

    // Cycle-by-cycle comparison of the WAIT_CYCLES=0 instance against the model
    always @(negedge CLK) begin
        if (RST_N && chk_on) begin
            chk("m req_ready", 32'(req_ready0), 32'(m_cs_left == 0 && !m_rsp_v));
            chk("m cs", 32'(cs0), 32'(m_cs_left > 0));
            if (m_cs_left > 0) begin
                chk("m we", 32'(we0), 32'(m_we));
                chk("m addr", addr0, m_addr);
                if (m_store) chk("m bus", bus0, m_bus);
            end else begin
                chk("m we idle", 32'(we0), 32'd0);
            end
            chk("m rsp_valid", 32'(rsp_valid0), 32'(m_rsp_v));
            if (m_rsp_v) begin
                chk("m rdata", rsp_rdata0, m_rdata);
                chk("m err", 32'(rsp_err0), 32'(m_err));
            end
        end
    end

    int cs_cnt0 = 0;
    logic [3:0]  we_seen0 = 4'b0;
    logic [31:0] bus_seen0 = 32'h0, addr_seen0 = 32'h0;
    always @(negedge CLK) begin
        if (cs0) begin
            cs_cnt0++; we_seen0 = we0; bus_seen0 = bus0; addr_seen0 = addr0;
        end
    end

    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input logic [3:0] exp_we, input logic [31:0] exp_bus, input int exp_cs,
                        input string nm);
        int n;
        bit got;
        @(negedge CLK);
        n = 0;
        while (!req_ready0 && n < 20) begin @(negedge CLK); n++; end
        chk({nm, " ready"}, 32'(req_ready0), 32'd1);
        cs_cnt0 = 0;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid0 = 1'b1;
        @(posedge CLK); #1;
        req_valid0 = 1'b0; req_addr = ~a; req_wdata = ~wd; req_funct3 = 3'b111; req_store = ~st;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin @(negedge CLK); got = rsp_valid0; end
        chk({nm, " rsp_valid"}, 32'(got), 32'd1);
        chk({nm, " rdata"}, rsp_rdata0, exp_rd);
        chk({nm, " err"}, 32'(rsp_err0), 32'(exp_err));
        chk({nm, " cs_cycles"}, cs_cnt0, exp_cs);
        if (exp_cs > 0) begin
            chk({nm, " we"}, 32'(we_seen0), 32'(exp_we));
            if (st) chk({nm, " bus"}, bus_seen0, exp_bus);
        end
    endtask

    initial begin
        int csn, vn, first_k;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) mb[i] = 8'h0;
        repeat (2) @(negedge CLK);
        chk("rst cs", 32'(cs0), 32'd0);
        chk("rst we", 32'(we0), 32'd0);
        chk("rst addr", addr0, 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("rst rdata", rsp_rdata0, 32'd0);
        chk("rst err", 32'(rsp_err0), 32'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        chk_on = 1'b1;

        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 1, "sw10");
        chk("sw10 addr", addr_seen0, 32'd4);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0, 1, "lw10");

        // WAIT_CYCLES=2 instance: CS length, latency, and response held under back-pressure
        @(negedge CLK);
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; rsp_ready1 = 1'b0; req_valid1 = 1'b1;
        @(posedge CLK); #1;
        req_valid1 = 1'b0; req_addr = 32'h0;
        csn = 0; vn = 0; first_k = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            if (cs1) csn++;
            if (rsp_valid1) begin
                if (first_k < 0) first_k = k;
                vn++;
                chk("w2 rdata", rsp_rdata1, 32'hDEADBEEF);
                if (vn == 4) rsp_ready1 = 1'b1;
            end
        end
        rsp_ready1 = 1'b1;
        chk("w2 cs_cycles", csn, 32'd3);
        chk("w2 valid_cycles", vn, 32'd4);
        chk("w2 latency", first_k, 32'd3);

        xact(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 1, "sb13");
        xact(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 4'b0000, 32'h0, 1, "lb13");
        xact(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 4'b0000, 32'h0, 1, "lbu13");
        xact(1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0, 4'b1100, 32'h80018001, 1, "sh22");
        xact(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0, 1, "lh22");
        xact(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 4'b0000, 32'h0, 1, "lhu22");
        xact(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "lw11 err");
        xact(1'b1, 3'b001, 32'h21, 32'h1234, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "sh21 err");
        xact(1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "sbu err");
        xact(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "f3_011 err");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'b0000, 32'h0, 1, "lw10 merged");

        // Reset asserted inside the ACCESS cycle of a store
        @(negedge CLK);
        @(negedge CLK);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678; req_valid0 = 1'b1;
        @(posedge CLK); #1;
        req_valid0 = 1'b0;
        #1 chk("prerst cs", 32'(cs0), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("midrst cs", 32'(cs0), 32'd0);
        chk("midrst we", 32'(we0), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid0), 32'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("postrst ready", 32'(req_ready0), 32'd1);
        chk("postrst cs", 32'(cs0), 32'd0);
        chk("postrst mem", mem[12], 32'h0);

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
